// File: rtl/beta_muldiv.sv
// Iterative signed/unsigned MUL, MULH, DIV, MOD for the Beta datapath, one operand bit per cycle.
// Latency: done is high WIDTH+1 cycles after the accept cycle, for every op and special case.
// Backpressure: start is ignored while busy=1 or flush=1; flush kills an in-flight op without a done.
module beta_muldiv #(
    parameter int WIDTH = 32,
    parameter int CW    = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             dz
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    localparam logic [1:0]    OP_MUL  = 2'b00;
    localparam logic [1:0]    OP_MULH = 2'b01;
    localparam logic [1:0]    OP_DIV  = 2'b10;
    localparam logic [1:0]    OP_MOD  = 2'b11;
    localparam logic [CW-1:0] LAST    = CW'(WIDTH - 1);

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [1:0]         op_q;
    logic               neg_q;
    logic               neg_r;
    logic               dz_p;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   opb;
    logic [2*WIDTH-1:0] acc;

    // Operand magnitudes formed at accept time.
    logic             sa;
    logic             sb;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;

    assign sa    = sgn & a[WIDTH-1];
    assign sb    = sgn & b[WIDTH-1];
    assign mag_a = sa ? -a : a;
    assign mag_b = sb ? -b : b;

    // Multiply step: add multiplicand into the upper half, shift the whole product right.
    logic [WIDTH:0]   mul_add;
    logic [WIDTH:0]   mul_sum;

    assign mul_add = {1'b0, (opb[0] ? opa : {WIDTH{1'b0}})};
    assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + mul_add;

    // Divide step: remainder lives in the upper half, quotient shifts into the lower half.
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] rem_nxt;

    assign div_sh   = {acc[2*WIDTH-1:WIDTH], opa[WIDTH-1]};
    assign div_diff = div_sh - {1'b0, opb};
    assign div_ge   = (div_sh >= {1'b0, opb});
    assign rem_nxt  = div_ge ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];

    // Sign fix-up and field select for the FIX cycle.
    logic [2*WIDTH-1:0] prod_f;
    logic [WIDTH-1:0]   quo_m;
    logic [WIDTH-1:0]   rem_m;
    logic [WIDTH-1:0]   quo_f;
    logic [WIDTH-1:0]   rem_f;
    logic [WIDTH-1:0]   fix_res;

    assign prod_f = neg_q ? -acc : acc;
    assign quo_m  = acc[WIDTH-1:0];
    assign rem_m  = acc[2*WIDTH-1:WIDTH];
    assign quo_f  = neg_q ? -quo_m : quo_m;
    assign rem_f  = neg_r ? -rem_m : rem_m;

    // With a zero divisor the remainder path already reproduces a; only DIV needs forcing.
    always_comb begin
        fix_res = '0;
        case (op_q)
            OP_MUL:  fix_res = prod_f[WIDTH-1:0];
            OP_MULH: fix_res = prod_f[2*WIDTH-1:WIDTH];
            OP_DIV:  fix_res = dz_p ? {WIDTH{1'b1}} : quo_f;
            OP_MOD:  fix_res = rem_f;
            default: fix_res = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= S_IDLE;
            cnt    <= '0;
            op_q   <= OP_MUL;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            dz_p   <= 1'b0;
            opa    <= '0;
            opb    <= '0;
            acc    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
            dz     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start && !flush) begin
                        op_q  <= op;
                        neg_q <= sa ^ sb;
                        neg_r <= sa;
                        dz_p  <= op[1] && (b == '0);
                        opa   <= mag_a;
                        opb   <= mag_b;
                        acc   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (flush) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        if (!op_q[1]) begin
                            acc <= {mul_sum, acc[WIDTH-1:1]};
                            opb <= opb >> 1;
                        end else begin
                            acc <= {rem_nxt, acc[WIDTH-2:0], div_ge};
                            opa <= opa << 1;
                        end
                        cnt <= cnt + CW'(1);
                        if (cnt == LAST) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        result <= fix_res;
                        dz     <= dz_p;
                        done   <= 1'b1;
                    end
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_beta_muldiv.sv
// Directed bench for beta_muldiv at WIDTH=32: arithmetic vectors, latency and protocol corner cases.
module tb_beta_muldiv;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [1:0]  op;
    logic        sgn;
    logic [31:0] a;
    logic [31:0] b;
    logic        flush;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        dz;

    int total;
    int bad;

    beta_muldiv #(.WIDTH(32)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .op      (op),
        .sgn     (sgn),
        .a       (a),
        .b       (b),
        .flush   (flush),
        .busy    (busy),
        .done    (done),
        .result  (result),
        .dz      (dz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drives a one-cycle start; returns at #1 after the accept edge.
    task automatic issue(input logic [1:0] o, input logic s, input logic [31:0] x, input logic [31:0] y);
        start = 1'b1;
        op    = o;
        sgn   = s;
        a     = x;
        b     = y;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Counts edges until done; base is the number of edges already elapsed since accept.
    task automatic wait_done(input int base, output int lat);
        lat = -1;
        for (int i = base + 1; i <= base + 60; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic s,
                          input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_r, input logic exp_dz);
        int lat;
        issue(o, s, x, y);
        wait_done(0, lat);
        chk({tag, "_lat"}, 64'(lat), 64'd33);
        chk({tag, "_res"}, {32'd0, result}, {32'd0, exp_r});
        chk({tag, "_dz"}, {63'd0, dz}, {63'd0, exp_dz});
    endtask

    // Watches n cycles and returns how many had done=1.
    task automatic count_done(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
    endtask

    initial begin
        int lat;
        int seen;
        total   = 0;
        bad     = 0;
        reset_n = 1'b0;
        start   = 1'b0;
        op      = 2'b00;
        sgn     = 1'b0;
        a       = '0;
        b       = '0;
        flush   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_res", {32'd0, result}, 64'd0);
        chk("rst_dz", {63'd0, dz}, 64'd0);

        // MUL signed -7 * 6, with busy checked right after accept
        issue(2'b00, 1'b1, 32'hFFFF_FFF9, 32'd6);
        chk("mul_busy", {63'd0, busy}, 64'd1);
        wait_done(0, lat);
        chk("mul_lat", 64'(lat), 64'd33);
        chk("mul_res", {32'd0, result}, 64'hFFFF_FFD6);
        chk("mul_dz", {63'd0, dz}, 64'd0);
        chk("mul_busy_done", {63'd0, busy}, 64'd0);

        run_op("mulh_u", 2'b01, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
        run_op("mulh_s", 2'b01, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op("div_s", 2'b10, 1'b1, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFD, 1'b0);
        run_op("mod_s", 2'b11, 1'b1, 32'hFFFF_FFEF, 32'd5, 32'hFFFF_FFFE, 1'b0);
        run_op("div_min", 2'b10, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
        run_op("mod_min", 2'b11, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
        run_op("div_u", 2'b10, 1'b0, 32'hFFFF_FFF0, 32'd16, 32'h0FFF_FFFF, 1'b0);
        run_op("div_z", 2'b10, 1'b0, 32'h0000_1234, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op("mod_z", 2'b11, 1'b0, 32'h0000_1234, 32'd0, 32'h0000_1234, 1'b1);
        run_op("div_zs", 2'b10, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFF, 1'b1);
        run_op("mod_zs", 2'b11, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1'b1);
        run_op("mul_clr", 2'b00, 1'b0, 32'd3, 32'd5, 32'd15, 1'b0);

        // start pulsed mid-RUN must be ignored
        issue(2'b00, 1'b0, 32'd100, 32'd3);
        repeat (5) @(posedge clk);
        #1;
        issue(2'b10, 1'b1, 32'd7, 32'd0);
        wait_done(6, lat);
        chk("ign_lat", 64'(lat), 64'd33);
        chk("ign_res", {32'd0, result}, 64'd300);
        chk("ign_dz", {63'd0, dz}, 64'd0);
        count_done(40, seen);
        chk("ign_nodone", 64'(seen), 64'd0);

        // flush in RUN cycle 10
        issue(2'b00, 1'b0, 32'd2, 32'd2);
        repeat (10) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("fl_busy", {63'd0, busy}, 64'd0);
        chk("fl_done", {63'd0, done}, 64'd0);
        count_done(40, seen);
        chk("fl_nodone", 64'(seen), 64'd0);
        chk("fl_res", {32'd0, result}, 64'd300);

        // start together with flush in IDLE is not accepted
        flush = 1'b1;
        issue(2'b00, 1'b0, 32'd9, 32'd9);
        flush = 1'b0;
        chk("sf_busy", {63'd0, busy}, 64'd0);
        count_done(40, seen);
        chk("sf_nodone", 64'(seen), 64'd0);

        // back-to-back: second start issued in the done cycle
        run_op("b2b_1", 2'b00, 1'b0, 32'd4, 32'd5, 32'd20, 1'b0);
        run_op("b2b_2", 2'b10, 1'b0, 32'd100, 32'd7, 32'd14, 1'b0);
        run_op("b2b_3", 2'b11, 1'b0, 32'd100, 32'd7, 32'd2, 1'b0);

        // one-cycle reset mid-RUN
        issue(2'b00, 1'b0, 32'd11, 32'd11);
        repeat (5) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        chk("mr_busy", {63'd0, busy}, 64'd0);
        chk("mr_done", {63'd0, done}, 64'd0);
        chk("mr_res", {32'd0, result}, 64'd0);
        chk("mr_dz", {63'd0, dz}, 64'd0);
        count_done(40, seen);
        chk("mr_nodone", 64'(seen), 64'd0);
        run_op("after_rst", 2'b10, 1'b0, 32'd1000, 32'd10, 32'd100, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
